// File: rtl/cmd_frame_rcvr.sv
// cmd_frame_rcvr: copter-side end of the wireless command link.
// Receives 8N1 bytes on RX and assembles {cmd, data_hi, data_lo} frames for the
// command handler. Sends single-byte responses on TX. The two directions are independent.
module cmd_frame_rcvr #(
  parameter int BAUD_DIV      = 2604,
  parameter int FRAME_TO_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam logic [11:0] FULL_M1  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_M1  = 12'(BAUD_DIV / 2 - 1);
  localparam int          TO_LIMIT = FRAME_TO_BITS * BAUD_DIV;
  localparam int          TOW      = $clog2(TO_LIMIT + 1);
  localparam logic [TOW-1:0] TO_M1 = TOW'(TO_LIMIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic       rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t  rx_state_r;
  logic [11:0] rx_cnt_r;
  logic [2:0] rx_bit_r;
  logic [7:0] rx_shift_r;

  frm_state_t frm_state_r;
  logic [7:0] stage_cmd_r;
  logic [7:0] stage_hi_r;
  logic [TOW-1:0] to_cnt_r;

  tx_state_t  tx_state_r;
  logic [11:0] tx_cnt_r;
  logic [2:0] tx_bit_r;
  logic [7:0] tx_shift_r;

  logic start_det_s, stop_smp_s, rx_done_s, rx_bad_s, frame_set_s, rdy_clr_s;

  // A start is a synchronized falling edge seen while the receiver is idle; the
  // stop bit is judged at its mid-point and the byte is valid only if it reads high.
  assign start_det_s = (rx_state_r == RX_IDLE) && rx_prev_r && !rx_sync_r;
  assign stop_smp_s  = (rx_state_r == RX_STOP) && (rx_cnt_r == FULL_M1);
  assign rx_done_s   = stop_smp_s && rx_sync_r;
  assign rx_bad_s    = stop_smp_s && !rx_sync_r;
  assign frame_set_s = rx_done_s && (frm_state_r == WAIT_LO);
  assign rdy_clr_s   = clr_cmd_rdy || (start_det_s && (frm_state_r == WAIT_CMD));

  // Two-flop synchronizer on the async RX line plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX bit engine: recheck start at half a bit, then sample data and stop mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 12'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= 12'd0;
          rx_bit_r <= 3'd0;
          if (start_det_s) rx_state_r <= RX_START;
          else             rx_state_r <= RX_IDLE;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_M1) begin
            rx_cnt_r <= 12'd0;
            // A line that is high again at mid-start was a glitch, not a byte.
            if (rx_sync_r) rx_state_r <= RX_IDLE;
            else           rx_state_r <= RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == FULL_M1) begin
            rx_cnt_r   <= 12'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
            else                  rx_bit_r   <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == FULL_M1) begin
            rx_cnt_r   <= 12'd0;
            rx_state_r <= RX_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + 12'd1;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          rx_cnt_r   <= 12'd0;
        end
      endcase
    end
  end

  // Frame assembly: stage opcode and high byte, publish all three together on the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_state_r <= WAIT_CMD;
      stage_cmd_r <= 8'h00;
      stage_hi_r  <= 8'h00;
      to_cnt_r    <= '0;
      cmd         <= 8'h00;
      data        <= 16'h0000;
      frm_err     <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (rx_bad_s) begin
        frm_state_r <= WAIT_CMD;
        frm_err     <= 1'b1;
        to_cnt_r    <= '0;
      end else if (rx_done_s) begin
        to_cnt_r <= '0;
        case (frm_state_r)
          WAIT_CMD: begin
            stage_cmd_r <= rx_shift_r;
            frm_state_r <= WAIT_HI;
          end
          WAIT_HI: begin
            stage_hi_r  <= rx_shift_r;
            frm_state_r <= WAIT_LO;
          end
          WAIT_LO: begin
            cmd         <= stage_cmd_r;
            data        <= {stage_hi_r, rx_shift_r};
            frm_state_r <= WAIT_CMD;
          end
          default: frm_state_r <= WAIT_CMD;
        endcase
      end else if (start_det_s) begin
        to_cnt_r <= '0;
      end else if ((frm_state_r != WAIT_CMD) && (rx_state_r == RX_IDLE)) begin
        // Master went quiet mid-frame: drop the staged bytes and resync on the next opcode.
        if (to_cnt_r == TO_M1) begin
          to_cnt_r    <= '0;
          frm_state_r <= WAIT_CMD;
          frm_err     <= 1'b1;
        end else begin
          to_cnt_r <= to_cnt_r + 1'b1;
        end
      end else if (frm_state_r == WAIT_CMD) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  // Ready flag: set on frame completion, which takes priority over any clear in the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy <= 1'b0;
    end else if (frame_set_s) begin
      cmd_rdy <= 1'b1;
    end else if (rdy_clr_s) begin
      cmd_rdy <= 1'b0;
    end else begin
      cmd_rdy <= cmd_rdy;
    end
  end

  // TX serializer: start, 8 data bits LSB first, stop; a new request may chain off the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 12'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      TX         <= 1'b1;
      tx_busy    <= 1'b0;
      resp_sent  <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state_r)
        TX_IDLE: begin
          tx_cnt_r <= 12'd0;
          tx_bit_r <= 3'd0;
          if (send_resp) begin
            tx_shift_r <= resp;
            TX         <= 1'b0;
            tx_busy    <= 1'b1;
            tx_state_r <= TX_START;
          end else begin
            TX      <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_r == FULL_M1) begin
            tx_cnt_r   <= 12'd0;
            tx_bit_r   <= 3'd0;
            TX         <= tx_shift_r[0];
            tx_state_r <= TX_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + 12'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == FULL_M1) begin
            tx_cnt_r <= 12'd0;
            if (tx_bit_r == 3'd7) begin
              TX         <= 1'b1;
              tx_state_r <= TX_STOP;
            end else begin
              TX         <= tx_shift_r[1];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_bit_r   <= tx_bit_r + 3'd1;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 12'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == FULL_M1) begin
            tx_cnt_r  <= 12'd0;
            resp_sent <= 1'b1;
            if (send_resp) begin
              tx_shift_r <= resp;
              TX         <= 1'b0;
              tx_busy    <= 1'b1;
              tx_state_r <= TX_START;
            end else begin
              TX         <= 1'b1;
              tx_busy    <= 1'b0;
              tx_state_r <= TX_IDLE;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 12'd1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          TX         <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
